// File: rtl/uart_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
//   uart_state_e : transmitter FSM states. PARITY is only entered when the
//                  design is built with UART_TX_PARITY_EN defined.
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit
//   IDLE_LINE    : line level while no frame is being sent
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and strobes bit_tick on the last cycle of each bit
// period. The counter restarts from zero whenever the FSM changes state, so
// every state begins on a fresh bit boundary.
// Ports:
//   clk      in  1      system clock, rising edge
//   reset    in  1      synchronous, active-high
//   clear    in  1      restart the bit period (asserted on a state change)
//   cnt      out CNT_W  current position inside the bit period
//   bit_tick out 1      high on the final cycle of a bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_tick
);

  assign bit_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter.
// Pops one byte from an upstream synchronous FIFO whenever it is non-empty
// (and enable is set while idle) and sends it as an 8N1 frame on tx, LSB first.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (8E1, 11 bit periods per frame).
// Ports:
//   clk        in  1       system clock, rising edge
//   reset      in  1       synchronous, active-high; aborts a frame in flight
//   enable     in  1       permits starting new frames; a started frame always completes
//   fifo_empty in  1       FIFO empty flag, only looked at while idle
//   fifo_rd_en out 1       one-cycle pop strobe per byte
//   fifo_data  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_en
//   tx         out 1       serial line, idle high
//   busy       out 1       high from the pop cycle through the end of the stop bit
//   tx_done    out 1       one-cycle pulse on the last cycle of the stop bit
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_e       state_q, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              bit_tick;
  logic [BIT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              tx_n;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_n != state_q),
    .cnt      (cnt),
    .bit_tick (bit_tick)
  );

  assign last_bit = (bit_cnt == BIT_W'(DATA_W - 1));

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:   if (enable && !fifo_empty) state_n = FETCH;
      FETCH:  state_n = LOAD;
      LOAD:   state_n = START;
      START:  if (bit_tick) state_n = DATA;
      DATA: begin
        if (bit_tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
      PARITY: if (bit_tick) state_n = STOP;
      STOP:   if (bit_tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so the line level is derived from the state and
  // shift contents the FSM will hold in the next cycle.
  always_comb begin
    shift_n = shift_q;
    if (state_q == LOAD) begin
      shift_n = fifo_data;
    end else if ((state_q == DATA) && bit_tick) begin
      shift_n = shift_q >> 1;
    end

    tx_n = IDLE_LINE;
    case (state_n)
      START:  tx_n = START_BIT;
      DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_n = par_q;
`else
      PARITY: tx_n = STOP_BIT;
`endif
      STOP:   tx_n = STOP_BIT;
      default: tx_n = IDLE_LINE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      tx         <= IDLE_LINE;
      bit_cnt    <= '0;
    end else begin
      state_q    <= state_n;
      fifo_rd_en <= (state_q == IDLE) && (state_n == FETCH);
      busy       <= (state_n != IDLE);
      // One cycle early so the registered pulse lands on the final stop cycle.
      tx_done    <= (state_q == STOP) && (cnt == CNT_W'(CLKS_PER_BIT - 2));
      tx         <= tx_n;
      if (state_q == DATA) begin
        if (bit_tick) begin
          bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
        end
      end else begin
        bit_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_n;
`ifdef UART_TX_PARITY_EN
    if (state_q == LOAD) begin
      par_q <= ^fifo_data;
    end
`endif
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx with CLKS_PER_BIT=4.
// A behavioural 16-deep synchronous FIFO feeds the DUT. A frame-level model
// predicts, cycle by cycle, the pop strobe, line level, busy and tx_done from
// the bytes written and the enable/empty/reset inputs.
// Honours UART_TX_PARITY_EN (8E1 frames) when defined.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Offset (from the pop cycle) of the last stop-bit cycle.
  localparam int LAST_OFF = 1 + FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = 8'h00;
  logic       tx, busy, tx_done;

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Source FIFO: registered data_out and empty flag, like fifo_sync.
  logic [7:0] fq[$];
  int         underflow = 0;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() == 0) underflow++;
      else fifo_data <= fq.pop_front();
    end
    if (wr_en && fq.size() < 16) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  // Reference model state.
  logic [7:0] ref_q[$];
  int         n_written = 0;
  int         rd_pulses = 0;
  int         cyc = 0;
  bit         armed = 1'b0;
  bit         in_frame = 1'b0;
  int         fetch_cyc = 0;
  logic [7:0] cur_byte = 8'h00;

  function automatic logic exp_line(input int off, input logic [7:0] b);
    int idx;
    if (off < 2) return 1'b1;
    idx = (off - 2) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    int   off;
    logic e_rd, e_busy, e_tx, e_done;
    cyc++;
    if (armed) begin
      e_rd = 1'b0; e_busy = 1'b0; e_tx = 1'b1; e_done = 1'b0;
      if (in_frame && cyc <= fetch_cyc + LAST_OFF) begin
        off    = cyc - fetch_cyc;
        e_rd   = (off == 0);
        e_busy = 1'b1;
        e_tx   = exp_line(off, cur_byte);
        e_done = (off == LAST_OFF);
      end
      chk("rd_en", fifo_rd_en, e_rd);
      chk("busy", busy, e_busy);
      chk("tx", tx, e_tx);
      chk("tx_done", tx_done, e_done);
      if (fifo_rd_en) rd_pulses++;
    end
    // Transition at the coming edge, from the inputs the DUT will sample.
    if (reset) begin
      in_frame = 1'b0;
      armed    = 1'b1;
    end else if (armed && (!in_frame || cyc > fetch_cyc + LAST_OFF) && enable && !fifo_empty) begin
      in_frame  = 1'b1;
      fetch_cyc = cyc + 1;
      if (ref_q.size() == 0) chk("ref_nonempty", 0, 1);
      else cur_byte = ref_q.pop_front();
    end else if (in_frame && cyc >= fetch_cyc + LAST_OFF) begin
      in_frame = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    ref_q.push_back(b);
    n_written++;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    int stable = 0;
    while (n < 3000 && stable < 4) begin
      tick(1);
      n++;
      if (fifo_empty && !busy && !fifo_rd_en && ref_q.size() == 0) stable++;
      else stable = 0;
    end
    if (stable < 4) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   n;
    logic seen;

    // Reset
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_tx_done", tx_done, 0);
    tick(2);

    // Single byte
    base = rd_pulses;
    enable = 1'b1;
    wr(8'hA5);
    wait_idle();
    chk("single_pops", rd_pulses - base, 1);
    chk("single_empty", fifo_empty, 1);

    // Burst of 16 into a full FIFO, then release
    enable = 1'b0;
    base = rd_pulses;
    for (int i = 1; i <= 16; i++) wr(8'(i));
    tick(5);
    chk("burst_held", rd_pulses - base, 0);
    enable = 1'b1;
    wait_idle();
    chk("burst_pops", rd_pulses - base, 16);

    // Empty FIFO with enable high
    base = rd_pulses;
    tick(50);
    chk("empty_no_pop", rd_pulses - base, 0);

    // Drop enable mid-frame; bytes waiting are not popped
    wr(8'h5A);
    tick(15);
    enable = 1'b0;
    base = rd_pulses;
    wr(8'hC3);
    wr(8'h81);
    tick(80);
    chk("disabled_no_pop", rd_pulses - base, 0);
    chk("disabled_idle", busy, 0);
    enable = 1'b1;
    wait_idle();

    // Reset during data bit 3 of 8'h3C
    wr(8'h3C);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      tick(1);
      n++;
      seen = fifo_rd_en;
    end
    if (!seen) chk("wait_rd", 0, 1);
    tick(19);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    wr(8'hE7);
    wait_idle();

    // Parity-sensitive bytes
    wr(8'h07);
    wr(8'h03);
    wait_idle();

    // Randomised traffic with enable toggling
    for (int i = 0; i < 30; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      if (ref_q.size() < 14) wr(8'($urandom_range(0, 255)));
      tick($urandom_range(0, 60));
    end
    enable = 1'b1;
    wait_idle();

    chk("underflow", underflow, 0);
    chk("total_pops", rd_pulses, n_written);
    chk("ref_left", ref_q.size(), 0);
    chk("end_empty", fifo_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
